// File: rtl/demux_1_2_reg.sv
// demux_1_2_reg: registered 1-to-2 stream demultiplexer. in_sel=0 steers the
//   input word to output A, in_sel=1 to output B. Each output owns a one-entry
//   holding register, so a stalled consumer only blocks words aimed at it.
// Latency: 1 cycle from input transfer to x_valid. Backpressure: in_ready is
//   the free state of the selected channel (x_free = !x_valid || x_ready).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_data/in_sel/in_valid   input word, destination select, word present
//   in_ready                  word accepted this cycle
//   a_data/a_valid/a_ready    output A stream
//   b_data/b_valid/b_ready    output B stream
//   cnt_a, cnt_b              delivered-transfer counters
// Build option: DEMUX_1_2_STATS_EN builds the 16-bit saturating counters;
//   without it cnt_a/cnt_b are tied to 0 and no counter flops exist.
module demux_1_2_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [15:0]      cnt_a,
  output logic [15:0]      cnt_b
);

  logic a_free;
  logic b_free;
  logic load_a;
  logic load_b;
  logic drain_a;
  logic drain_b;

  // A slot is free when empty or being drained this cycle, which lets a
  // full channel accept a new word on the same edge it hands one off.
  assign a_free   = !a_valid || a_ready;
  assign b_free   = !b_valid || b_ready;
  assign in_ready = in_sel ? b_free : a_free;

  assign load_a  = in_valid && in_ready && !in_sel;
  assign load_b  = in_valid && in_ready &&  in_sel;
  assign drain_a = a_valid && a_ready;
  assign drain_b = b_valid && b_ready;

  // Load takes priority over drain so a simultaneous drain/load keeps the
  // channel valid with the new word (no bubble).
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_data  <= '0;
    end else if (load_a) begin
      a_valid <= 1'b1;
      a_data  <= in_data;
    end else if (drain_a) begin
      a_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid <= 1'b0;
      b_data  <= '0;
    end else if (load_b) begin
      b_valid <= 1'b1;
      b_data  <= in_data;
    end else if (drain_b) begin
      b_valid <= 1'b0;
    end
  end

`ifdef DEMUX_1_2_STATS_EN
  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (drain_a && (cnt_a != 16'hFFFF)) cnt_a <= cnt_a + 16'd1;
      if (drain_b && (cnt_b != 16'hFFFF)) cnt_b <= cnt_b + 16'd1;
    end
  end
`else
  assign cnt_a = 16'd0;
  assign cnt_b = 16'd0;
`endif

endmodule

// File: tb/tb_demux_1_2_reg.sv
// tb_demux_1_2_reg: directed stimulus for demux_1_2_reg with a scoreboard.
// Accepted words are queued per channel; a negedge monitor pops and compares
// on every output handshake. Directed checks cover reset, latency and stalls.
module tb_demux_1_2_reg;

`ifdef DEMUX_1_2_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_data;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] b_data;
  logic        b_valid;
  logic        b_ready;
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;

  demux_1_2_reg #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [15:0] exp_a = 16'd0;
  logic [15:0] exp_b = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_valid && a_ready) begin
        if (qa.size() == 0) chk("a_unexpected_word", a_data, 32'hxxxx_xxxx);
        else chk("a_data_order", a_data, qa.pop_front());
        if (exp_a != 16'hFFFF) exp_a = exp_a + 16'd1;
      end
      if (b_valid && b_ready) begin
        if (qb.size() == 0) chk("b_unexpected_word", b_data, 32'hxxxx_xxxx);
        else chk("b_data_order", b_data, qb.pop_front());
        if (exp_b != 16'hFFFF) exp_b = exp_b + 16'd1;
      end
    end
  end

  // Present one word and hold it until accepted; waits counts stalled cycles.
  task automatic send(input logic [31:0] d, input logic s, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    while (!ok && waits <= TMO) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else waits++;
    end
    if (ok) begin
      @(posedge clk); #1;
      if (s) qb.push_back(d);
      else qa.push_back(d);
    end else begin
      chk("send_timeout", 32'(waits), 32'd0);
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_cnt_a"}, {16'd0, cnt_a}, STATS ? {16'd0, exp_a} : 32'd0);
    chk({tag, "_cnt_b"}, {16'd0, cnt_b}, STATS ? {16'd0, exp_b} : 32'd0);
  endtask

  initial begin
    int w;
    rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h1234;
    a_ready = 1'b0; b_ready = 1'b0;

    // Reset held two cycles with a word offered: nothing may be captured.
    repeat (2) begin
      @(negedge clk);
      chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
      chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
      chk("rst_a_data", a_data, 32'd0);
      chk("rst_b_data", b_data, 32'd0);
      chk("rst_cnt", {cnt_a, cnt_b}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_a_valid", {31'd0, a_valid}, 32'd0);
      chk("post_rst_b_valid", {31'd0, b_valid}, 32'd0);
    end
    @(posedge clk); #1;

    // Basic routing with 1-cycle latency.
    a_ready = 1'b1; b_ready = 1'b1;
    send(32'hAAAA0001, 1'b0, w);
    chk("route_a_wait", 32'(w), 32'd0);
    chk("route_a_valid", {31'd0, a_valid}, 32'd1);
    chk("route_a_data", a_data, 32'hAAAA0001);
    send(32'hBBBB0002, 1'b1, w);
    chk("route_b_wait", 32'(w), 32'd0);
    chk("route_b_valid", {31'd0, b_valid}, 32'd1);
    chk("route_b_data", b_data, 32'hBBBB0002);
    repeat (2) @(posedge clk); #1;
    chk_cnt("route");

    // Back-to-back throughput on A.
    for (int i = 0; i < 8; i++) begin
      send(32'(i), 1'b0, w);
      chk("b2b_wait", 32'(w), 32'd0);
      chk("b2b_a_valid", {31'd0, a_valid}, 32'd1);
      chk("b2b_a_data", a_data, 32'(i));
    end
    repeat (2) @(posedge clk); #1;
    chk("b2b_a_drained", {31'd0, a_valid}, 32'd0);
    chk_cnt("b2b");

    // Stall isolation: A stalled holding 5, B keeps flowing.
    a_ready = 1'b0;
    send(32'h5, 1'b0, w);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h6;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_a_data", a_data, 32'h5);
      chk("stall_a_valid", {31'd0, a_valid}, 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    send(32'h9, 1'b1, w);
    chk("stall_b_wait", 32'(w), 32'd0);
    chk("stall_b_valid", {31'd0, b_valid}, 32'd1);
    chk("stall_b_data", b_data, 32'h9);
    chk("stall_a_hold", a_data, 32'h5);
    a_ready = 1'b1;
    send(32'h6, 1'b0, w);
    chk("unstall_wait", 32'(w), 32'd0);
    chk("unstall_a_data", a_data, 32'h6);
    repeat (2) @(posedge clk); #1;

    // Simultaneous drain and load keeps A valid with the new word.
    send(32'h10, 1'b0, w);
    send(32'h11, 1'b0, w);
    chk("dl_wait", 32'(w), 32'd0);
    chk("dl_a_valid", {31'd0, a_valid}, 32'd1);
    chk("dl_a_data", a_data, 32'h11);
    repeat (2) @(posedge clk); #1;
    chk_cnt("dl");

`ifdef DEMUX_1_2_STATS_EN
    // Saturation: push A past 16'hFFFF transfers.
    for (int i = 0; i < 65540; i++) send(32'(i), 1'b0, w);
    repeat (3) @(posedge clk); #1;
    chk("sat_cnt_a", {16'd0, cnt_a}, 32'h0000FFFF);
    chk_cnt("sat");
`endif

    repeat (3) @(posedge clk); #1;
    chk("end_qa_empty", 32'(qa.size()), 32'd0);
    chk("end_qb_empty", 32'(qb.size()), 32'd0);
    chk_cnt("end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
